// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision compare stage: op codes,
// IEEE-754 special-value constants and NaN classification helpers.
package fp_pkg;

  typedef enum logic [2:0] {
    OP_FEQ  = 3'd0,
    OP_FLT  = 3'd1,
    OP_FLE  = 3'd2,
    OP_FMIN = 3'd3,
    OP_FMAX = 3'd4
  } fp_op_e;

  localparam logic [31:0] QNAN_CANON   = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam int unsigned QNAN_BIT     = 32'd22;

  // Any NaN: exponent saturated and a non-zero fraction.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_ALL_ONES) && (x[22:0] != 23'd0);
  endfunction

  // Signalling NaN: a NaN whose quiet bit is clear.
  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[QNAN_BIT];
  endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// Combinational IEEE-754 single-precision ordering core. eq/lt describe the
// numeric relation of two non-NaN operands (+0 and -0 compare equal); both
// are forced low whenever either operand is a NaN.
module fp_cmp_core
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt,
  output logic        a_nan,
  output logic        b_nan,
  output logic        a_snan,
  output logic        b_snan
);

  logic w_any_nan;
  logic w_both_zero;
  logic w_mag_lt;
  logic w_mag_gt;

  assign a_nan       = is_nan(a);
  assign b_nan       = is_nan(b);
  assign a_snan      = is_snan(a);
  assign b_snan      = is_snan(b);
  assign w_any_nan   = a_nan || b_nan;
  assign w_both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
  assign w_mag_lt    = a[30:0] < b[30:0];
  assign w_mag_gt    = a[30:0] > b[30:0];
  assign eq          = !w_any_nan && ((a == b) || w_both_zero);

  // Sign-magnitude ordering: differing signs decide directly, negative
  // values order by reversed magnitude.
  always_comb begin
    lt = 1'b0;
    if (w_any_nan) begin
      lt = 1'b0;
    end else if (w_both_zero) begin
      lt = 1'b0;
    end else if (a[31] != b[31]) begin
      lt = a[31];
    end else if (a[31]) begin
      lt = w_mag_gt;
    end else begin
      lt = w_mag_lt;
    end
  end

endmodule

// File: rtl/fp_cmp_stage.sv
// Two-entry pipelined FP compare / min / max stage with valid-ready
// handshakes on both sides. S1 holds the operands, S2 holds the result.
module fp_cmp_stage
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        nv_flag
);

  logic        r_s1_valid;
  logic [2:0]  r_s1_op;
  logic [31:0] r_s1_a;
  logic [31:0] r_s1_b;
  logic        r_s2_valid;
  logic [31:0] r_s2_result;
  logic        r_s2_nv;

  logic        w_s1_adv;
  logic        w_s1_load;
  logic        w_accept;
  logic        w_eq;
  logic        w_lt;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_snan;
  logic        w_b_snan;
  logic        w_any_nan;
  logic        w_any_snan;
  logic [31:0] w_res;
  logic        w_nv;

  // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
  assign w_s1_adv   = !r_s2_valid || out_ready;
  assign w_s1_load  = !r_s1_valid || w_s1_adv;
  assign in_ready   = w_s1_load || flush;
  assign w_accept   = in_valid && w_s1_load && !flush;

  assign out_valid  = r_s2_valid;
  assign result     = r_s2_result;
  assign nv_flag    = r_s2_nv;

  assign w_any_nan  = w_a_nan || w_b_nan;
  assign w_any_snan = w_a_snan || w_b_snan;

  fp_cmp_core u_core (
    .a      (r_s1_a),
    .b      (r_s1_b),
    .eq     (w_eq),
    .lt     (w_lt),
    .a_nan  (w_a_nan),
    .b_nan  (w_b_nan),
    .a_snan (w_a_snan),
    .b_snan (w_b_snan)
  );

  // Result/flag selection for the op held in S1. In the min/max equal case
  // the operands are either bit-identical or opposite zeros, so the sign
  // bit picks -0 for min and +0 for max.
  always_comb begin
    w_res = 32'h0000_0000;
    w_nv  = 1'b0;
    case (r_s1_op)
      OP_FEQ: begin
        w_res = {31'd0, w_eq};
        w_nv  = w_any_snan;
      end
      OP_FLT: begin
        w_res = {31'd0, w_lt};
        w_nv  = w_any_nan;
      end
      OP_FLE: begin
        w_res = {31'd0, (w_lt || w_eq)};
        w_nv  = w_any_nan;
      end
      OP_FMIN: begin
        w_nv = w_any_snan;
        if (w_a_nan && w_b_nan) begin
          w_res = QNAN_CANON;
        end else if (w_a_nan) begin
          w_res = r_s1_b;
        end else if (w_b_nan) begin
          w_res = r_s1_a;
        end else if (w_eq) begin
          w_res = r_s1_a[31] ? r_s1_a : r_s1_b;
        end else if (w_lt) begin
          w_res = r_s1_a;
        end else begin
          w_res = r_s1_b;
        end
      end
      OP_FMAX: begin
        w_nv = w_any_snan;
        if (w_a_nan && w_b_nan) begin
          w_res = QNAN_CANON;
        end else if (w_a_nan) begin
          w_res = r_s1_b;
        end else if (w_b_nan) begin
          w_res = r_s1_a;
        end else if (w_eq) begin
          w_res = r_s1_a[31] ? r_s1_b : r_s1_a;
        end else if (w_lt) begin
          w_res = r_s1_b;
        end else begin
          w_res = r_s1_a;
        end
      end
      default: begin
        w_res = 32'h0000_0000;
        w_nv  = 1'b0;
      end
    endcase
  end

  // Stage occupancy: reset and flush empty both stages, otherwise each
  // stage refills from its upstream neighbour when allowed to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
      end
    end
  end

  // S1 operand capture on an accepted beat; no reset needed on datapath.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_op <= in_op;
      r_s1_a  <= fp_a;
      r_s1_b  <= fp_b;
    end
  end

  // S2 result capture; holds stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_result <= 32'h0000_0000;
      r_s2_nv     <= 1'b0;
    end else if (!flush && w_s1_adv && r_s1_valid) begin
      r_s2_result <= w_res;
      r_s2_nv     <= w_nv;
    end
  end

endmodule
